// File: rtl/trackball_pkg.sv
// Shared constants and helpers for the trackball quadrature emulator:
// speed codes, the quadrature gray table and a symmetric saturating add.
package trackball_pkg;

    localparam logic [2:0] SPD_X1 = 3'd0;
    localparam logic [2:0] SPD_X2 = 3'd1;
    localparam logic [2:0] SPD_X4 = 3'd2;
    localparam logic [2:0] SPD_Q  = 3'd3;
    localparam logic [2:0] SPD_H  = 3'd4;

    // Working width for accumulator arithmetic; wide enough for any ACC_W <= 29.
    localparam int unsigned SAT_W = 32;

    // {A,B} per phase, phase 0 in the low pair: 0->00, 1->01, 2->11, 3->10.
    localparam logic [7:0] GRAY_TBL = 8'b10_11_01_00;

    function automatic logic [1:0] gray_of(input logic [1:0] phase);
        return GRAY_TBL[{phase, 1'b0} +: 2];
    endfunction

    // acc + add - sub, clamped symmetrically to +/-(2^(acc_w-1)-1).
    function automatic logic signed [SAT_W-1:0] sat_sum(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] add,
        input logic signed [SAT_W-1:0] sub,
        input int unsigned             acc_w
    );
        logic signed [SAT_W-1:0] lim;
        logic signed [SAT_W-1:0] sum;
        lim = (SAT_W'(1) <<< (acc_w - 1)) - SAT_W'(1);
        sum = acc + add - sub;
        if (sum > lim) begin
            sum = lim;
        end else if (sum < -lim) begin
            sum = -lim;
        end
        return sum;
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: pending-count accumulator, step timer and output encoder.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   pkt, scaled       packet strobe and its already-scaled delta
//   flip              invert driven direction
//   step_period       a step every step_period+1 cycles while pending
//   out_a, out_b      clk/dir (QUAD=0) or quadrature A/B (QUAD=1)
//   busy              accumulator non-zero
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned QUAD  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pkt,
    input  logic signed [ACC_W-1:0] scaled,
    input  logic                    flip,
    input  logic [15:0]             step_period,
    output logic                    out_a,
    output logic                    out_b,
    output logic                    busy
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             timer_q, timer_d;
    logic [1:0]              phase_q, phase_d;
    logic                    step_q, step_d;
    logic                    out_a_q, out_a_d;
    logic                    out_b_q, out_b_d;
    logic                    busy_q, busy_d;

    logic                    step_c;
    logic                    pos_c;
    logic                    dir_c;
    logic signed [SAT_W-1:0] add_c;
    logic signed [SAT_W-1:0] sub_c;
    logic signed [SAT_W-1:0] sum_c;

    // Next-state: packet and step folded into one saturating update.
    always_comb begin
        pos_c   = ~acc_q[ACC_W-1];
        step_c  = (acc_q != '0) && (timer_q >= step_period);
        dir_c   = pos_c ^ flip;
        add_c   = pkt ? SAT_W'(scaled) : SAT_W'(0);
        sub_c   = step_c ? (pos_c ? SAT_W'(1) : -SAT_W'(1)) : SAT_W'(0);
        sum_c   = sat_sum(SAT_W'(acc_q), add_c, sub_c, ACC_W);
        acc_d   = ACC_W'(sum_c);
        timer_d = ((acc_q == '0) || step_c) ? 16'd0 : timer_q + 16'd1;
        phase_d = phase_q;
        step_d  = step_c;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        busy_d  = (acc_d != '0);

        if (step_c) begin
            phase_d = dir_c ? 2'(phase_q + 2'd1) : 2'(phase_q - 2'd1);
        end

        if (QUAD != 0) begin
            {out_a_d, out_b_d} = gray_of(phase_q);
        end else begin
            // dir updates in the step cycle; clk toggles one cycle later
            if (step_c) begin
                out_b_d = dir_c;
            end
            out_a_d = out_a_q ^ step_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            timer_q <= '0;
            phase_q <= '0;
            step_q  <= 1'b0;
            out_a_q <= 1'b0;
            out_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            busy_q  <= busy_d;
        end
    end

    assign out_a = out_a_q;
    assign out_b = out_b_q;
    assign busy  = busy_q;

endmodule

// File: rtl/trackball_quad_emu.sv
// Multi-axis trackball emulator: turns relative motion packets into step
// pulses (clk/dir or quadrature) at a programmable rate.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   in_toggle      packet strobe, every level change is a packet
//   in_delta       AXES signed DW-bit deltas, axis i at [i*DW +: DW]
//   speed          0:x1 1:x2 2:x4 3:/4 4:/2 others:x1
//   flip           per-axis direction inversion
//   step_period    step spacing minus one
//   out_a, out_b   per-axis clk/dir or A/B
//   busy           per-axis pending counts
module trackball_quad_emu
    import trackball_pkg::*;
#(
    parameter int unsigned AXES  = 2,
    parameter int unsigned DW    = 9,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned QUAD  = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_toggle,
    input  logic [AXES*DW-1:0]   in_delta,
    input  logic [2:0]           speed,
    input  logic [AXES-1:0]      flip,
    input  logic [15:0]          step_period,
    output logic [AXES-1:0]      out_a,
    output logic [AXES-1:0]      out_b,
    output logic [AXES-1:0]      busy
);

    logic tog_q, tog_d;
    logic pkt_c;

    // Packet detect on any level change of in_toggle.
    always_comb begin
        tog_d = in_toggle;
        pkt_c = (in_toggle != tog_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        logic signed [ACC_W-1:0] raw_c;
        logic signed [ACC_W-1:0] bias_c;
        logic signed [ACC_W-1:0] scaled_c;

        // Speed scaling; right shifts bias negatives so they round toward zero.
        always_comb begin
            raw_c    = ACC_W'($signed(in_delta[i*DW +: DW]));
            bias_c   = '0;
            scaled_c = raw_c;
            case (speed)
                SPD_X1: scaled_c = raw_c;
                SPD_X2: scaled_c = raw_c <<< 1;
                SPD_X4: scaled_c = raw_c <<< 2;
                SPD_Q: begin
                    if (raw_c[ACC_W-1]) begin
                        bias_c = ACC_W'(3);
                    end
                    scaled_c = (raw_c + bias_c) >>> 2;
                end
                SPD_H: begin
                    if (raw_c[ACC_W-1]) begin
                        bias_c = ACC_W'(1);
                    end
                    scaled_c = (raw_c + bias_c) >>> 1;
                end
                default: scaled_c = raw_c;
            endcase
        end

        trackball_axis #(
            .ACC_W (ACC_W),
            .QUAD  (QUAD)
        ) u_axis (
            .clk         (clk),
            .reset_n     (reset_n),
            .pkt         (pkt_c),
            .scaled      (scaled_c),
            .flip        (flip[i]),
            .step_period (step_period),
            .out_a       (out_a[i]),
            .out_b       (out_b[i]),
            .busy        (busy[i])
        );
    end

endmodule

// File: tb/tb_trackball_quad_emu.sv
// Bench for trackball_quad_emu: one clk/dir instance and one quadrature instance.
module tb_trackball_quad_emu;

    localparam int unsigned AXES  = 2;
    localparam int unsigned DW    = 9;
    localparam int unsigned ACC_W = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 tog0, tog1;
    logic [AXES*DW-1:0]   delta0, delta1;
    logic [2:0]           speed;
    logic [AXES-1:0]      flip0, flip1;
    logic [15:0]          period;
    logic [AXES-1:0]      a0, b0, busy0;
    logic [AXES-1:0]      a1, b1, busy1;

    always #5 clk = ~clk;

    trackball_quad_emu #(.AXES(AXES), .DW(DW), .ACC_W(ACC_W), .QUAD(0)) d0 (
        .clk(clk), .reset_n(rst_n), .in_toggle(tog0), .in_delta(delta0),
        .speed(speed), .flip(flip0), .step_period(period),
        .out_a(a0), .out_b(b0), .busy(busy0)
    );

    trackball_quad_emu #(.AXES(AXES), .DW(DW), .ACC_W(ACC_W), .QUAD(1)) d1 (
        .clk(clk), .reset_n(rst_n), .in_toggle(tog1), .in_delta(delta1),
        .speed(speed), .flip(flip1), .step_period(period),
        .out_a(a1), .out_b(b1), .busy(busy1)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboards: expected clk/dir steps of d0 axis 0, expected {A,B} of d1 axis 0.
    typedef struct {
        logic dir;
        int   gap;
    } step_exp_t;

    step_exp_t  q0[$];
    logic [1:0] q1[$];
    step_exp_t  e0;
    logic [1:0] e1;
    logic [1:0] cur_ab;

    int         cyc      = 0;
    int         last_tog = 0;
    int         steps0   = 0;
    int         tog_ax1  = 0;
    logic       prev_a0  = 1'b0;
    logic       prev_a01 = 1'b0;
    logic [1:0] prev_ab1 = 2'b00;

    function automatic int acc_peek(input int ax);
        if (ax == 0) return int'(d0.g_axis[0].u_axis.acc_q);
        return int'(d0.g_axis[1].u_axis.acc_q);
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        cur_ab = {a1[0], b1[0]};
        if (rst_n) begin
            if (a0[0] != prev_a0) begin
                steps0++;
                check("step_expected0", int'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    check("dir0", int'(b0[0]), int'(e0.dir));
                    if (e0.gap != 0) check("gap0", cyc - last_tog, e0.gap);
                end
                last_tog = cyc;
            end
            if (cur_ab != prev_ab1) begin
                check("ab_one_bit", $countones(cur_ab ^ prev_ab1), 1);
                check("ab_expected", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    check("gray1", int'(cur_ab), int'(e1));
                end
            end
            if (a0[1] != prev_a01) tog_ax1++;
        end
        prev_a0  = a0[0];
        prev_a01 = a0[1];
        prev_ab1 = cur_ab;
    end

    task automatic pkt0(input int dx0, input int dx1);
        @(negedge clk);
        delta0 = {DW'(dx1), DW'(dx0)};
        tog0   = ~tog0;
    endtask

    task automatic pkt1(input int dx0);
        @(negedge clk);
        delta1 = {DW'(0), DW'(dx0)};
        tog1   = ~tog1;
    endtask

    // Park the strobes low with zero deltas, then pulse reset.
    task automatic do_reset();
        @(negedge clk);
        delta0 = '0;
        delta1 = '0;
        tog0   = 1'b0;
        tog1   = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 400 && (q0.size() > 0 || q1.size() > 0); n++) @(negedge clk);
        check(name, q0.size() + q1.size(), 0);
    endtask

    typedef struct {
        logic [2:0] spd;
        int         d0;
        int         d1;
        int         e0;
        int         e1;
    } vec_t;

    vec_t vt[10];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        vt[0] = '{3'd0,    5,   -7,    5,    -7};
        vt[1] = '{3'd1,  100, -100,  200,  -200};
        vt[2] = '{3'd2,  100, -256,  400, -1024};
        vt[3] = '{3'd3,   -3,   -5,    0,    -1};
        vt[4] = '{3'd3,    7,   -4,    1,    -1};
        vt[5] = '{3'd4,   -1,   -3,    0,    -1};
        vt[6] = '{3'd4,    5,  255,    2,   127};
        vt[7] = '{3'd6,   -9,   13,   -9,    13};
        vt[8] = '{3'd7,  255, -256,  255,  -256};
        vt[9] = '{3'd3, -255,  255,  -63,    63};

        rst_n  = 1'b0;
        tog0   = 1'b0;
        tog1   = 1'b0;
        delta0 = '0;
        delta1 = '0;
        speed  = 3'd0;
        flip0  = '0;
        flip1  = '0;
        period = 16'd3;
        repeat (3) @(negedge clk);
        check("rst_a0", int'(a0), 0);
        check("rst_b0", int'(b0), 0);
        check("rst_busy0", int'(busy0), 0);
        check("rst_a1", int'(a1), 0);
        check("rst_b1", int'(b1), 0);
        check("rst_busy1", int'(busy1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scaling table, no steps can fire at the longest period.
        period = 16'hFFFF;
        foreach (vt[k]) begin
            do_reset();
            speed = vt[k].spd;
            pkt0(vt[k].d0, vt[k].d1);
            @(negedge clk);
            check($sformatf("acc0_v%0d", k), acc_peek(0), vt[k].e0);
            check($sformatf("acc1_v%0d", k), acc_peek(1), vt[k].e1);
            check($sformatf("busy0_v%0d", k), int'(busy0[0]), int'(vt[k].e0 != 0));
            check($sformatf("busy1_v%0d", k), int'(busy0[1]), int'(vt[k].e1 != 0));
        end

        // +5 at period 3: five clk edges four cycles apart, dir high.
        do_reset();
        speed  = 3'd0;
        period = 16'd3;
        s0     = steps0;
        for (int k = 0; k < 5; k++) q0.push_back('{1'b1, (k == 0) ? 0 : 4});
        pkt0(5, 0);
        wait_drain("t1_drain");
        repeat (10) @(negedge clk);
        check("t1_steps", steps0 - s0, 5);
        check("t1_busy", int'(busy0[0]), 0);
        check("t1_acc", acc_peek(0), 0);
        check("t1_dir_hold", int'(b0[0]), 1);

        // Quadrature, -3 then -3 with flip.
        do_reset();
        period = 16'd1;
        flip1  = '0;
        q1.push_back(2'b10); q1.push_back(2'b11); q1.push_back(2'b01);
        pkt1(-3);
        wait_drain("t2_drain");
        do_reset();
        flip1 = 2'b01;
        q1.push_back(2'b01); q1.push_back(2'b11); q1.push_back(2'b10);
        pkt1(-3);
        wait_drain("t2f_drain");
        repeat (5) @(negedge clk);
        check("t2_busy", int'(busy1[0]), 0);
        flip1 = '0;

        // Quarter speed: -3 vanishes, -5 -> one down step, +7 -> one up step.
        do_reset();
        speed  = 3'd3;
        period = 16'd0;
        s0     = steps0;
        pkt0(-3, 0);
        repeat (5) @(negedge clk);
        check("t3_zero_busy", int'(busy0[0]), 0);
        q0.push_back('{1'b0, 0});
        pkt0(-5, 0);
        wait_drain("t3_neg_drain");
        q0.push_back('{1'b1, 0});
        pkt0(7, 0);
        wait_drain("t3_pos_drain");
        repeat (3) @(negedge clk);
        check("t3_steps", steps0 - s0, 2);
        check("t3_acc", acc_peek(0), 0);

        // Saturation at both limits, then a packet back from the limit.
        do_reset();
        speed  = 3'd1;
        period = 16'hFFFF;
        for (int k = 0; k < 10; k++) pkt0(255, -255);
        @(negedge clk);
        check("t4_sat_pos", acc_peek(0), 2047);
        check("t4_sat_neg", acc_peek(1), -2047);
        pkt0(-255, 255);
        @(negedge clk);
        check("t4_back_pos", acc_peek(0), 1537);
        check("t4_back_neg", acc_peek(1), -1537);

        // Packet of +4 lands in the step cycle of acc=+1.
        do_reset();
        speed  = 3'd0;
        period = 16'd0;
        s0     = steps0;
        for (int k = 0; k < 5; k++) q0.push_back('{1'b1, (k == 0) ? 0 : 1});
        pkt0(1, 0);
        pkt0(4, 0);
        @(negedge clk);
        check("t5_acc", acc_peek(0), 4);
        wait_drain("t5_drain");
        repeat (5) @(negedge clk);
        check("t5_steps", steps0 - s0, 5);

        // Reset in the middle of a +20 drain.
        do_reset();
        period = 16'd3;
        for (int k = 0; k < 20; k++) q0.push_back('{1'b1, (k == 0) ? 0 : 4});
        pkt0(20, 0);
        repeat (30) @(negedge clk);
        check("t6_busy_pre", int'(busy0[0]), 1);
        check("t6_dir_pre", int'(b0[0]), 1);
        #2 rst_n = 1'b0;
        q0.delete();
        #1;
        check("t6_async_a", int'(a0), 0);
        check("t6_async_b", int'(b0), 0);
        check("t6_async_busy", int'(busy0), 0);
        delta0 = '0;
        tog0   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s0    = steps0;
        repeat (60) @(negedge clk);
        check("t6_no_steps", steps0 - s0, 0);
        check("t6_acc", acc_peek(0), 0);
        check("t6_busy", int'(busy0[0]), 0);
        q0.push_back('{1'b1, 0}); q0.push_back('{1'b1, 4});
        pkt0(2, 0);
        wait_drain("t6_resume");

        check("ax1_no_steps", tog_ax1, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
